adc_osr_multichannel: RTL and testbench
=======================================

# adc_osr_multichannel

Parametrised multi-channel oversampling and decimation unit for the SAR-ADC digital core. It sits between the nonbinary SAR control block and the result interface. It accumulates 4^m conversion results per channel, where m is the OSR mode, and emits one right-shifted result of DATA_WIDTH+m bits per completed block. Results are tagged with their channel index and buffered in a small valid/ready output FIFO.

## Interface
- DATA_WIDTH, 12: width of raw SAR result.
- OUT_WIDTH, 16: output width; must satisfy OUT_WIDTH >= DATA_WIDTH+MAX_MODE.
- MAX_MODE, 4: highest OSR mode (4^4 = 256 samples).
- CHANNELS, 4: number of independent channels (>=2). CW = $clog2(CHANNELS).
- FIFO_DEPTH, 2: output buffer entries (>=1).
- clk  in  1  conversion clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  one-cycle strobe: data_in/channel_in hold a finished conversion.
- data_in  in  DATA_WIDTH  raw conversion result.
- channel_in  in  CW  channel tag of data_in.
- osr_mode_in  in  3  requested OSR mode m.
- data_out  out  OUT_WIDTH  decimated result (FIFO head).
- channel_out  out  CW  channel of FIFO head.
- valid_out  out  1  FIFO non-empty.
- ready_in  in  1  consumer accepts head when valid_out&ready_in.
- result_strobe_out  out  1  one-cycle pulse when a result is pushed into the FIFO.
- overflow_out  out  1  sticky: a result was dropped on FIFO full.

## Operation
- Reset (async, rst_n low): all accumulators, sample counters, FIFO pointers, data_out, channel_out, valid_out, result_strobe_out and overflow_out go to 0. mode_q goes to 0.
- Effective mode: m = min(osr_mode_in, MAX_MODE). It is registered in mode_q every cycle.
- Mode change: if the clamped osr_mode_in differs from mode_q, all channel accumulators and counters clear on that edge. An ena in that cycle is discarded.
- Per-channel state:
  - acc[c], DATA_WIDTH+2*MAX_MODE bits, unsigned.
  - cnt[c], 2*MAX_MODE bits.
- On ena with channel_in < CHANNELS and no mode change:
  - sum = acc[c] + data_in.
  - If cnt[c] == 4^m-1: push {c, sum >> m} zero-extended to OUT_WIDTH, then clear acc[c] and cnt[c].
  - Otherwise acc[c] <= sum and cnt[c] increments.
- ena with channel_in >= CHANNELS: ignored, no state change.
- m = 0: every sample is pushed unchanged (pass-through).
- Arithmetic: the sum never overflows, since the max is 4^MAX_MODE*(2^DATA_WIDTH-1). The result is exact truncation, no rounding.
- FIFO:
  - Push is accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the result is dropped and overflow_out is set. It clears only on reset.
  - The dropped block still clears that channel's accumulator.
- result_strobe_out pulses only for accepted pushes.
- Channels are fully independent. Interleaved ena on different channels does not disturb other accumulators.

## Timing
- Latency: the ena edge carrying the final sample of a block produces valid_out=1 and data_out/channel_out valid in the next cycle (FIFO previously empty). result_strobe_out is high in that same next cycle.
- data_out/channel_out are registered FIFO head outputs. They are stable while valid_out=1 and ready_in=0.
- Pop on the edge where valid_out&ready_in. The next entry, if any, appears the following cycle with no bubble.
- Throughput: one ena per cycle sustained. Full-rate output in m=0 requires ready_in held high.
- Reset mid-block: partial sums are lost. Counting restarts from zero after rst_n deasserts.

## Test plan
- Reset: assert rst_n low mid-stream -> all outputs 0 immediately (async). After release, valid_out=0 until a block completes.
- m=0, ch1, data 0xABC, ready_in=1 -> next cycle valid_out=1, data_out=0x0ABC, channel_out=1, result_strobe_out=1.
- m=1, ch0 samples 100,101,102,103 -> single result 203 (406>>1). With ch2 samples 4,4,4,4 interleaved -> second result 8 on channel 2, order by completion.
- m=2, 16 samples of 4095 on ch3 -> data_out=16380 (65520>>2). m=4, 256×4095 -> 65520, no overflow.
- FIFO_DEPTH=2, ready_in=0, m=0, three samples -> first two held, third dropped, overflow_out=1 sticky. Then ready_in=1 -> heads pop in order and valid_out falls after 2 pops.
- Mode change 1->2 after 2 samples on ch0 -> accumulator cleared, ena in the change cycle dropped. 16 fresh samples of 8 -> result 32.

Source files
------------

// File: rtl/adc_osr_multichannel.sv
// Multi-channel oversampling/decimation unit: sums 4^m samples per channel and
// pushes the shifted block sum, tagged with its channel, into a small output FIFO.
module adc_osr_multichannel #(
  parameter int DATA_WIDTH = 12,
  parameter int OUT_WIDTH  = 16,
  parameter int MAX_MODE   = 4,
  parameter int CHANNELS   = 4,
  parameter int FIFO_DEPTH = 2,
  localparam int CW        = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CW-1:0]         channel_in,
  input  logic [2:0]            osr_mode_in,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic [CW-1:0]         channel_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  result_strobe_out,
  output logic                  overflow_out
);

  localparam int AW = DATA_WIDTH + 2 * MAX_MODE;
  localparam int NW = 2 * MAX_MODE;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH + 1);

  logic [2:0]           mode_q, mode_d;
  logic [AW-1:0]        acc_q [CHANNELS];
  logic [AW-1:0]        acc_d [CHANNELS];
  logic [NW-1:0]        cnt_q [CHANNELS];
  logic [NW-1:0]        cnt_d [CHANNELS];
  logic [OUT_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0] mem_data_d [FIFO_DEPTH];
  logic [CW-1:0]        mem_ch_q [FIFO_DEPTH];
  logic [CW-1:0]        mem_ch_d [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic [CW-1:0]        channel_out_q, channel_out_d;
  logic                 valid_out_q, valid_out_d;
  logic                 strobe_q, strobe_d;
  logic                 overflow_q, overflow_d;

  logic [2:0]           mode_req;
  logic                 mode_change;
  logic                 ch_ok;
  logic                 blk_last;
  logic [AW-1:0]        sum;
  logic [OUT_WIDTH-1:0] push_data;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mode_req    = (osr_mode_in > 3'(MAX_MODE)) ? 3'(MAX_MODE) : osr_mode_in;
    mode_change = (mode_req != mode_q);
    ch_ok       = ({1'b0, channel_in} < (CW + 1)'(CHANNELS));
    sum         = acc_q[channel_in] + AW'(data_in);
    // Block length is 4^m, so the last sample sits at count 4^m - 1.
    blk_last    = ({1'b0, cnt_q[channel_in]} ==
                   (((NW + 1)'(1) << {mode_q, 1'b0}) - (NW + 1)'(1)));
    push_data   = OUT_WIDTH'(sum >> mode_q);
    push        = ena & ch_ok & ~mode_change & blk_last;
    pop         = valid_out_q & ready_in;
    full        = (fifo_cnt_q == FW'(FIFO_DEPTH));
    push_ok     = push & (~full | pop);
  end

  always_comb begin
    mode_d     = mode_req;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    strobe_d   = push_ok;
    overflow_d = overflow_q | (push & ~push_ok);
    if (mode_change) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_d[c] = '0;
        cnt_d[c] = '0;
      end
    end else if (ena && ch_ok) begin
      if (blk_last) begin
        acc_d[channel_in] = '0;
        cnt_d[channel_in] = '0;
      end else begin
        acc_d[channel_in] = sum;
        cnt_d[channel_in] = cnt_q[channel_in] + NW'(1);
      end
    end
  end

  // Head registers load from the post-update FIFO state so a pop shows the next entry without a bubble.
  always_comb begin
    mem_data_d    = mem_data_q;
    mem_ch_d      = mem_ch_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    data_out_d    = data_out_q;
    channel_out_d = channel_out_q;
    if (push_ok) begin
      mem_data_d[wr_ptr_q] = push_data;
      mem_ch_d[wr_ptr_q]   = channel_in;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    valid_out_d = (fifo_cnt_d != '0);
    if (valid_out_d) begin
      data_out_d    = mem_data_d[rd_ptr_d];
      channel_out_d = mem_ch_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_ch_q[i]   <= '0;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      data_out_q    <= '0;
      channel_out_q <= '0;
      valid_out_q   <= 1'b0;
      strobe_q      <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      mem_data_q    <= mem_data_d;
      mem_ch_q      <= mem_ch_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      data_out_q    <= data_out_d;
      channel_out_q <= channel_out_d;
      valid_out_q   <= valid_out_d;
      strobe_q      <= strobe_d;
      overflow_q    <= overflow_d;
    end
  end

  assign data_out          = data_out_q;
  assign channel_out       = channel_out_q;
  assign valid_out         = valid_out_q;
  assign result_strobe_out = strobe_q;
  assign overflow_out      = overflow_q;

endmodule

// File: tb/tb_adc_osr_multichannel.sv
// Scoreboard bench for adc_osr_multichannel: a behavioural model queues expected
// results as samples are driven; the monitor compares the FIFO head each cycle.
module tb_adc_osr_multichannel;

  localparam int DW  = 12;
  localparam int OW  = 16;
  localparam int MM  = 4;
  localparam int NCH = 4;
  localparam int FD  = 2;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [CW-1:0] channel_in = '0;
  logic [2:0]    osr_mode_in = '0;
  logic          ready_in = 1'b0;
  logic [OW-1:0] data_out;
  logic [CW-1:0] channel_out;
  logic          valid_out;
  logic          result_strobe_out;
  logic          overflow_out;

  adc_osr_multichannel #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .MAX_MODE(MM), .CHANNELS(NCH), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .channel_in(channel_in),
    .osr_mode_in(osr_mode_in), .data_out(data_out), .channel_out(channel_out),
    .valid_out(valid_out), .ready_in(ready_in), .result_strobe_out(result_strobe_out),
    .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int data;
  } res_t;

  int     checks = 0;
  int     failures = 0;
  res_t   expQ[$];
  res_t   gotQ[$];
  longint mAcc[NCH];
  int     mCnt[NCH];
  int     mMode = 0;
  bit     expStrobe = 1'b0;
  bit     expOvf = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    expQ.delete();
    expStrobe = 1'b0;
    expOvf    = 1'b0;
    mMode     = 0;
    for (int c = 0; c < NCH; c++) begin
      mAcc[c] = 0;
      mCnt[c] = 0;
    end
  endtask

  // Predicts what the coming rising edge does with the inputs currently driven.
  task automatic modelEdge();
    int     mIn;
    int     c;
    longint s;
    mIn = (osr_mode_in > 3'(MM)) ? MM : int'(osr_mode_in);
    expStrobe = 1'b0;
    if (mIn != mMode) begin
      for (int k = 0; k < NCH; k++) begin
        mAcc[k] = 0;
        mCnt[k] = 0;
      end
    end else if (ena && (int'(channel_in) < NCH)) begin
      c = int'(channel_in);
      s = mAcc[c] + longint'(data_in);
      if (mCnt[c] == (1 << (2 * mMode)) - 1) begin
        mAcc[c] = 0;
        mCnt[c] = 0;
        if (expQ.size() < FD) begin
          expQ.push_back('{c, int'(s >> mMode)});
          expStrobe = 1'b1;
        end else begin
          expOvf = 1'b1;
        end
      end else begin
        mAcc[c] = s;
        mCnt[c]++;
      end
    end
    mMode = mIn;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      resetModel();
    end else begin
      checkOutput("valid_out", {31'd0, valid_out}, {31'd0, expQ.size() != 0});
      checkOutput("result_strobe_out", {31'd0, result_strobe_out}, {31'd0, expStrobe});
      checkOutput("overflow_out", {31'd0, overflow_out}, {31'd0, expOvf});
      if (expQ.size() != 0) begin
        checkOutput("data_out", 32'(data_out), 32'(expQ[0].data));
        checkOutput("channel_out", 32'(channel_out), 32'(expQ[0].ch));
        if (ready_in) begin
          gotQ.push_back('{int'(channel_out), int'(data_out)});
          void'(expQ.pop_front());
        end
      end
      modelEdge();
    end
  end

  task automatic applyStimulus(input int ch, input int data);
    @(posedge clk);
    #1;
    ena        = 1'b1;
    channel_in = CW'(ch);
    data_in    = DW'(data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ena = 1'b0;
    end
  endtask

  task automatic setMode(input int m);
    @(posedge clk);
    #1;
    ena         = 1'b0;
    osr_mode_in = 3'(m);
    idle(1);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    ready_in = 1'b1;
    while (expQ.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain timeout", 32'(expQ.size()), 32'd0);
    idle(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    resetModel();
    #1;
    checkOutput("reset valid_out", {31'd0, valid_out}, 32'd0);
    checkOutput("reset data_out", 32'(data_out), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Pass-through on channel 1
    ready_in = 1'b1;
    applyStimulus(1, 'hABC);
    idle(1);
    checkOutput("m0 valid", {31'd0, valid_out}, 32'd1);
    checkOutput("m0 data", 32'(data_out), 32'h0ABC);
    checkOutput("m0 channel", 32'(channel_out), 32'd1);
    checkOutput("m0 strobe", {31'd0, result_strobe_out}, 32'd1);
    waitDrain();

    // m=1 with interleaved channels 0 and 2
    gotQ.delete();
    setMode(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 100 + i);
      applyStimulus(2, 4);
    end
    idle(1);
    waitDrain();
    checkOutput("m1 count", 32'(gotQ.size()), 32'd2);
    if (gotQ.size() == 2) begin
      checkOutput("m1 first data", 32'(gotQ[0].data), 32'd203);
      checkOutput("m1 first ch", 32'(gotQ[0].ch), 32'd0);
      checkOutput("m1 second data", 32'(gotQ[1].data), 32'd8);
      checkOutput("m1 second ch", 32'(gotQ[1].ch), 32'd2);
    end

    // m=2 full-scale on channel 3, then m=4 full-scale on channel 1
    gotQ.delete();
    setMode(2);
    for (int i = 0; i < 16; i++) applyStimulus(3, 4095);
    idle(1);
    waitDrain();
    setMode(4);
    for (int i = 0; i < 256; i++) applyStimulus(1, 4095);
    idle(1);
    waitDrain();
    checkOutput("m2/m4 count", 32'(gotQ.size()), 32'd2);
    if (gotQ.size() == 2) begin
      checkOutput("m2 data", 32'(gotQ[0].data), 32'd16380);
      checkOutput("m2 ch", 32'(gotQ[0].ch), 32'd3);
      checkOutput("m4 data", 32'(gotQ[1].data), 32'd65520);
    end
    checkOutput("m4 no overflow", {31'd0, overflow_out}, 32'd0);

    // FIFO full: third result dropped, overflow sticky
    gotQ.delete();
    setMode(0);
    ready_in = 1'b0;
    applyStimulus(0, 1);
    applyStimulus(1, 2);
    applyStimulus(2, 3);
    idle(1);
    checkOutput("ovf set", {31'd0, overflow_out}, 32'd1);
    checkOutput("ovf head data", 32'(data_out), 32'd1);
    idle(2);
    checkOutput("ovf head held", 32'(data_out), 32'd1);
    waitDrain();
    checkOutput("ovf pops", 32'(gotQ.size()), 32'd2);
    if (gotQ.size() == 2) begin
      checkOutput("ovf pop0", 32'(gotQ[0].data), 32'd1);
      checkOutput("ovf pop1", 32'(gotQ[1].data), 32'd2);
    end
    checkOutput("ovf drained valid", {31'd0, valid_out}, 32'd0);
    checkOutput("ovf sticky", {31'd0, overflow_out}, 32'd1);

    // Mode change 1->2 mid-block discards partial sum and the change-cycle sample
    gotQ.delete();
    setMode(1);
    applyStimulus(0, 100);
    applyStimulus(0, 100);
    @(posedge clk);
    #1;
    osr_mode_in = 3'd2;
    ena         = 1'b1;
    channel_in  = '0;
    data_in     = DW'(999);
    for (int i = 0; i < 16; i++) applyStimulus(0, 8);
    idle(1);
    waitDrain();
    checkOutput("modechg count", 32'(gotQ.size()), 32'd1);
    if (gotQ.size() == 1) checkOutput("modechg data", 32'(gotQ[0].data), 32'd32);

    // Asynchronous reset mid-stream with a held result and a partial block
    gotQ.delete();
    setMode(0);
    ready_in = 1'b0;
    applyStimulus(2, 'h123);
    setMode(1);
    applyStimulus(0, 10);
    applyStimulus(0, 10);
    @(posedge clk);
    #3;
    ena   = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("arst valid_out", {31'd0, valid_out}, 32'd0);
    checkOutput("arst data_out", 32'(data_out), 32'd0);
    checkOutput("arst channel_out", 32'(channel_out), 32'd0);
    checkOutput("arst overflow_out", {31'd0, overflow_out}, 32'd0);
    checkOutput("arst strobe", {31'd0, result_strobe_out}, 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    ready_in = 1'b1;
    idle(1);
    checkOutput("post-reset valid", {31'd0, valid_out}, 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 10);
    idle(1);
    waitDrain();
    checkOutput("post-reset count", 32'(gotQ.size()), 32'd1);
    if (gotQ.size() == 1) checkOutput("post-reset data", 32'(gotQ[0].data), 32'd20);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
